// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: datapath width, register-index width, ALU opcodes.
package id_ex_stage_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass select for one source register: EX/MEM beats MEM/WB, x0 is never bypassed.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [REG_IDX_W-1:0] addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic                 exmem_we,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]      exmem_data,
    input  logic                 memwb_we,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]      memwb_data,
    output logic [XLEN-1:0]      data
);

    always_comb begin
        data = rf_data;
        if (addr != '0) begin
            if (exmem_we && (exmem_rd == addr))
                data = exmem_data;
            else if (memwb_we && (memwb_rd == addr))
                data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and flush. Define ID_EX_FWD_EN to
// bypass EX/MEM and MEM/WB results into the operands; otherwise a load-use style interlock stalls decode.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_IDX_W-1:0] id_rs1_addr,
    input  logic [REG_IDX_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic                 id_use_imm,
    input  logic [2:0]           id_alu_op,
    input  logic                 id_funct7,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 fwd_exmem_we,
    input  logic [REG_IDX_W-1:0] fwd_exmem_rd,
    input  logic [XLEN-1:0]      fwd_exmem_data,
    input  logic                 fwd_memwb_we,
    input  logic [REG_IDX_W-1:0] fwd_memwb_rd,
    input  logic [XLEN-1:0]      fwd_memwb_data,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      operand_a,
    output logic [XLEN-1:0]      operand_b,
    output logic [2:0]           alu_op,
    output logic                 funct7,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_reg_write
);

    logic [XLEN-1:0] rs1_p0;
    logic [XLEN-1:0] rs2_p0;
    logic            hazard_p0;
    logic            accept_p0;

`ifdef ID_EX_FWD_EN
    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr       (id_rs1_addr),
        .rf_data    (id_rs1_data),
        .exmem_we   (fwd_exmem_we),
        .exmem_rd   (fwd_exmem_rd),
        .exmem_data (fwd_exmem_data),
        .memwb_we   (fwd_memwb_we),
        .memwb_rd   (fwd_memwb_rd),
        .memwb_data (fwd_memwb_data),
        .data       (rs1_p0)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr       (id_rs2_addr),
        .rf_data    (id_rs2_data),
        .exmem_we   (fwd_exmem_we),
        .exmem_rd   (fwd_exmem_rd),
        .exmem_data (fwd_exmem_data),
        .memwb_we   (fwd_memwb_we),
        .memwb_rd   (fwd_memwb_rd),
        .memwb_data (fwd_memwb_data),
        .data       (rs2_p0)
    );

    assign hazard_p0 = 1'b0;
`else
    logic unused_fwd;

    assign rs1_p0 = id_rs1_data;
    assign rs2_p0 = id_rs2_data;

    // Without bypassing, a source that names the held destination must wait until it retires.
    assign hazard_p0 = id_valid && ex_valid && ex_reg_write && (ex_rd != '0) &&
                       ((ex_rd == id_rs1_addr) || ((ex_rd == id_rs2_addr) && !id_use_imm));

    assign unused_fwd = ^{fwd_exmem_we, fwd_exmem_rd, fwd_exmem_data,
                          fwd_memwb_we, fwd_memwb_rd, fwd_memwb_data};
`endif

    assign id_ready  = !flush && (!ex_valid || ex_ready) && !hazard_p0;
    assign accept_p0 = id_valid && id_ready;

    // ---- capture boundary: operands are resolved now and never re-forwarded while held ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            operand_a    <= '0;
            operand_b    <= '0;
            alu_op       <= ALU_ADD;
            funct7       <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
        end else begin
            if (flush)
                ex_valid <= 1'b0;
            else if (accept_p0)
                ex_valid <= 1'b1;
            else if (ex_ready)
                ex_valid <= 1'b0;

            if (accept_p0) begin
                operand_a    <= rs1_p0;
                operand_b    <= id_use_imm ? id_imm : rs2_p0;
                alu_op       <= id_alu_op;
                funct7       <= id_funct7;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write && (id_rd != '0);
            end
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and immediate.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  decode presents an instruction.
REQ-005 id_ready  output  1  stage accepts the instruction this cycle.
REQ-006 id_rs1_addr, id_rs2_addr  input  5 each  source register indices.
REQ-007 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
REQ-008 id_imm  input  XLEN  sign-extended immediate; id_use_imm input 1 selects it for operand B.
REQ-009 id_alu_op  input  3  ALU operation; id_funct7 input 1  funct7 modifier bit.
REQ-010 id_rd  input  5  destination; id_reg_write input 1  destination write enable.
REQ-011 fwd_exmem_we input 1, fwd_exmem_rd input 5, fwd_exmem_data input XLEN  EX/MEM result.
REQ-012 fwd_memwb_we input 1, fwd_memwb_rd input 5, fwd_memwb_data input XLEN  MEM/WB result.
REQ-013 flush  input  1  discard held and incoming instruction (branch redirect).
REQ-014 ex_ready  input  1  ALU stage consumes the held instruction.
REQ-015 ex_valid output 1; operand_a, operand_b output XLEN; alu_op output 3; funct7 output 1; ex_rd output 5; ex_reg_write output 1 -- registered, directly drive the ALU ports of the same names.

Function
REQ-016 Single register stage, latency exactly 1 cycle from accept to ex_valid.
REQ-017 Accept = id_valid && id_ready; id_ready = (!ex_valid || ex_ready) && !hazard (hazard per REQ-028, else 0).
REQ-018 On accept, all ex_* / operand / control registers load; ex_valid sets to 1.
REQ-019 ex_valid && ex_ready && !accept -> ex_valid clears to 0; payload registers hold.
REQ-020 ex_valid && !ex_ready -> all outputs hold unchanged (stall).
REQ-021 Simultaneous consume and accept -> new instruction loaded, ex_valid stays 1, no bubble.
REQ-022 flush -> ex_valid 0 next cycle, overrides accept; id_ready driven 0 while flush is high.
REQ-023 Forwarding of a source: EX/MEM match (we && rd==addr && rd!=0) wins over MEM/WB match; else register-file data.
REQ-024 Source index 0 never forwarded; value is id_rsN_data.
REQ-025 operand_a = forwarded rs1; operand_b = id_use_imm ? id_imm : forwarded rs2.
REQ-026 ex_reg_write forced 0 when id_rd==0.
REQ-027 Forwarding evaluated combinationally at capture cycle only; held operands never re-forwarded.

Reset
REQ-028 (hazard) Defined only without ID_EX_FWD_EN: hazard = id_valid && ex_valid && ex_reg_write && ex_rd!=0 && (ex_rd==id_rs1_addr || (ex_rd==id_rs2_addr && !id_use_imm)).
REQ-029 rst high -> ex_valid, operand_a, operand_b, alu_op, funct7, ex_rd, ex_reg_write all 0 immediately, regardless of clock.
REQ-030 Reset mid-stall drops the held instruction; first cycle after release id_ready = 1.

Configuration
REQ-031 Macro ID_EX_FWD_EN defined -> forwarding muxes per REQ-023..024, hazard = 0.
REQ-032 ID_EX_FWD_EN undefined -> fwd_* inputs ignored, operands from id_rs*_data, interlock per REQ-028 stalls decode.

Structure
REQ-033 Shared package holds XLEN default, alu_op encoding enum (3 bit), and register-index width constant.
REQ-034 One sub-module fwd_mux (one instance per source) implements REQ-023..024.

Verification
REQ-035 Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 same cycle, id_ready=1 after release.
REQ-036 Accept alu_op=3'b000, rs1_data=5, imm=7, use_imm=1, ex_ready=1 -> next cycle ex_valid=1, operand_a=5, operand_b=7.
REQ-037 FWD_EN: rs1_addr=3, exmem rd=3 data=0xAA, memwb rd=3 data=0xBB -> operand_a=0xAA; rs1_addr=0 with exmem rd=0 -> rf data.
REQ-038 ex_ready=0 for 3 cycles with new id_valid -> outputs stable, id_ready=0; ex_ready=1 -> back-to-back load, no bubble.
REQ-039 flush with id_valid=1 and ex_valid=1 -> ex_valid=0 next cycle, incoming instruction not captured.
REQ-040 No FWD_EN: held ex_rd=5 reg_write=1, incoming rs2_addr=5 use_imm=0 -> id_ready=0 until ex_ready consumes it.
